// File: rtl/noc_buffer_ctrl_pkg.sv
// Shared NoC buffer definitions.
// Holds the flit geometry, the default buffer dimensions, the
// counter-update encoding and the mod-LENGTH pointer helper.
package noc_buffer_ctrl_pkg;

    localparam int unsigned FLIT_WIDTH         = 18;
    localparam int unsigned TAIL_BIT           = FLIT_WIDTH - 1;
    localparam int unsigned DEFAULT_LENGTH     = 64;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 6;

    // Per-cycle update applied to an occupancy-style counter.
    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_CLR
    } cnt_op_e;

    // Pointer advance that wraps at an arbitrary depth, not a power of two.
    function automatic int unsigned next_ptr(input int unsigned p,
                                             input int unsigned length);
        return (p == length - 1) ? 32'd0 : p + 32'd1;
    endfunction

endpackage

// File: rtl/noc_buffer_ctrl_if.sv
// Flit handshake and memory-pin bundle of the router input-port buffer.
//   upstream   : in_valid / in_data / in_ready
//   downstream : out_valid / out_data / out_ready
//   memory     : mem_write / mem_write_addr / mem_write_data,
//                mem_read / mem_read_addr / mem_read_data (async read)
// master : the buffer controller side.
// slave  : the surrounding wrapper (link, allocator and memory).
interface noc_buffer_ctrl_if
    import noc_buffer_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = FLIT_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  in_valid;
    logic [WIDTH-1:0]      in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_ready;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [WIDTH-1:0]      mem_write_data;
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [WIDTH-1:0]      mem_read_data;

    modport master (
        input  in_valid, in_data, out_ready, mem_read_data,
        output in_ready, out_valid, out_data,
               mem_write, mem_write_addr, mem_write_data,
               mem_read, mem_read_addr
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_read_data,
        input  in_ready, out_valid, out_data,
               mem_write, mem_write_addr, mem_write_data,
               mem_read, mem_read_addr
    );

endinterface

// File: rtl/noc_buffer_ctrl_wrap_ptr.sv
// wrap_ptr: mod-LENGTH address counter.
//   clk, rst (async, active-low), clr (sync clear, wins over en),
//   en (advance by one), ptr (current address).
module wrap_ptr
    import noc_buffer_ctrl_pkg::*;
#(
    parameter int unsigned LENGTH     = DEFAULT_LENGTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] ptr
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (en) begin
            ptr_d = ADDR_WIDTH'(next_ptr(32'(ptr_q), LENGTH));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/noc_buffer_ctrl.sv
// noc_buffer_ctrl: FIFO controller for an external async-read /
// sync-write flit memory (router input-port buffer).
//   clk, rst (async, active-low), flush (sync clear of pointers/counters)
//   bus       : flit handshakes and memory pins (master side)
//   count     : flits stored, 0..LENGTH
//   pkt_count : tail flits stored
//   full, empty : decoded from the registered count
module noc_buffer_ctrl
    import noc_buffer_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = FLIT_WIDTH,
    parameter int unsigned LENGTH     = DEFAULT_LENGTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    noc_buffer_ctrl_if.master     bus,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic                  full,
    output logic                  empty
);

    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   pkt_count_q, pkt_count_d;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  push, pop;
    logic                  tail_in, tail_out;
    cnt_op_e               cnt_op, pkt_op;

    // Status comes only from registered count: no in_valid->in_ready or
    // out_ready->out_valid path, and no full-passthrough / empty-bypass.
    assign full          = (count_q == (ADDR_WIDTH + 1)'(LENGTH));
    assign empty         = (count_q == '0);
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;

    // Flush suppresses the write so memory and pointers stay consistent.
    assign push = bus.in_valid & bus.in_ready & !flush;
    assign pop  = bus.out_valid & bus.out_ready;

    assign bus.mem_write      = push;
    assign bus.mem_write_addr = wr_ptr;
    assign bus.mem_write_data = bus.in_data;
    assign bus.mem_read       = !empty;
    assign bus.mem_read_addr  = rd_ptr;
    assign bus.out_data       = bus.mem_read_data;

    assign tail_in  = bus.in_data[WIDTH-1];
    assign tail_out = bus.mem_read_data[WIDTH-1];

    wrap_ptr #(.LENGTH(LENGTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (push),
        .ptr (wr_ptr)
    );

    wrap_ptr #(.LENGTH(LENGTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (pop),
        .ptr (rd_ptr)
    );

    always_comb begin
        cnt_op = CNT_HOLD;
        pkt_op = CNT_HOLD;
        if (flush) begin
            cnt_op = CNT_CLR;
            pkt_op = CNT_CLR;
        end else begin
            if (push && !pop) begin
                cnt_op = CNT_INC;
            end else if (pop && !push) begin
                cnt_op = CNT_DEC;
            end
            if ((push && tail_in) && !(pop && tail_out)) begin
                pkt_op = CNT_INC;
            end else if ((pop && tail_out) && !(push && tail_in)) begin
                pkt_op = CNT_DEC;
            end
        end
    end

    always_comb begin
        count_d     = count_q;
        pkt_count_d = pkt_count_q;
        case (cnt_op)
            CNT_INC: count_d = count_q + 1'b1;
            CNT_DEC: count_d = count_q - 1'b1;
            CNT_CLR: count_d = '0;
            default: count_d = count_q;
        endcase
        case (pkt_op)
            CNT_INC: pkt_count_d = pkt_count_q + 1'b1;
            CNT_DEC: pkt_count_d = pkt_count_q - 1'b1;
            CNT_CLR: pkt_count_d = '0;
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign count     = count_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_noc_buffer_ctrl.sv
// Directed bench for noc_buffer_ctrl: a 64-deep instance for the main
// sequences and a 5-deep instance for non-power-of-two wrap streaming.
// Each instance is paired with a small async-read flit memory.
module tb_noc_buffer_ctrl;

    localparam int unsigned W = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: LENGTH 64 ----------------
    logic       rst_a   = 1'b0;
    logic       flush_a = 1'b0;
    logic [6:0] count_a, pkt_a;
    logic       full_a, empty_a;
    logic [W-1:0] mem_a [64];

    noc_buffer_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(6)) bus_a ();

    noc_buffer_ctrl #(.WIDTH(W), .LENGTH(64), .ADDR_WIDTH(6)) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .flush     (flush_a),
        .bus       (bus_a.master),
        .count     (count_a),
        .pkt_count (pkt_a),
        .full      (full_a),
        .empty     (empty_a)
    );

    always @(posedge clk) if (bus_a.mem_write) mem_a[bus_a.mem_write_addr] <= bus_a.mem_write_data;
    assign bus_a.mem_read_data = mem_a[bus_a.mem_read_addr];

    // ---------------- instance B: LENGTH 5 ----------------
    logic       rst_b = 1'b0;
    logic [3:0] count_b, pkt_b;
    logic       full_b, empty_b;
    logic [W-1:0] mem_b [8];

    noc_buffer_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(3)) bus_b ();

    noc_buffer_ctrl #(.WIDTH(W), .LENGTH(5), .ADDR_WIDTH(3)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .flush     (1'b0),
        .bus       (bus_b.master),
        .count     (count_b),
        .pkt_count (pkt_b),
        .full      (full_b),
        .empty     (empty_b)
    );

    always @(posedge clk) if (bus_b.mem_write) mem_b[bus_b.mem_write_addr] <= bus_b.mem_write_data;
    assign bus_b.mem_read_data = mem_b[bus_b.mem_read_addr];

    function automatic logic [W-1:0] stream_flit(input int unsigned n);
        return {(n % 4) == 3, 17'(n + 32'h100)};
    endfunction

    task automatic push_a(input logic [W-1:0] d);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        tick();
        bus_a.in_valid = 1'b0;
    endtask

    task automatic flush_pulse_a();
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
    endtask

    logic [W-1:0] first3 [3];

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
        first3[0] = 18'h00001; first3[1] = 18'h00002; first3[2] = 18'h20003;

        // Reset state
        #12;
        check("rst_empty",     32'(empty_a), 32'd1);
        check("rst_full",      32'(full_a), 32'd0);
        check("rst_in_ready",  32'(bus_a.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_mem_write", 32'(bus_a.mem_write), 32'd0);
        check("rst_mem_read",  32'(bus_a.mem_read), 32'd0);
        check("rst_count",     32'(count_a), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();

        // Three pushes, no pops
        for (int i = 0; i < 3; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_data  = first3[i];
            #1;
            check("p3_wr_addr", 32'(bus_a.mem_write_addr), 32'(i));
            check("p3_mem_write", 32'(bus_a.mem_write), 32'd1);
            tick();
        end
        bus_a.in_valid = 1'b0;
        check("p3_count", 32'(count_a), 32'd3);
        check("p3_pkt",   32'(pkt_a), 32'd1);
        check("p3_head",  32'(bus_a.out_data), 32'h00001);

        // Fill 64 with out_ready low
        flush_pulse_a();
        check("flush_count", 32'(count_a), 32'd0);
        for (int i = 0; i < 64; i++) push_a(18'(i));
        check("fill_full",     32'(full_a), 32'd1);
        check("fill_in_ready", 32'(bus_a.in_ready), 32'd0);
        check("fill_count",    32'(count_a), 32'd64);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 18'h3ffff;
        #1;
        check("fill65_mem_write", 32'(bus_a.mem_write), 32'd0);
        tick();
        bus_a.in_valid = 1'b0;
        check("fill65_count", 32'(count_a), 32'd64);

        // Full with simultaneous valid/ready: only the pop happens
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 18'h00abc;
        bus_a.out_ready = 1'b1;
        #1;
        check("fullpop_in_ready", 32'(bus_a.in_ready), 32'd0);
        check("fullpop_head",     32'(bus_a.out_data), 32'd0);
        tick();
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b0;
        check("fullpop_count",    32'(count_a), 32'd63);
        check("fullpop_ready_up", 32'(bus_a.in_ready), 32'd1);
        check("fullpop_next",     32'(bus_a.out_data), 32'd1);

        // Flush with in_valid at count 7
        flush_pulse_a();
        for (int i = 0; i < 7; i++) push_a({(i % 3) == 0, 17'(i + 32'h40)});
        check("pre_flush_count", 32'(count_a), 32'd7);
        check("pre_flush_pkt",   32'(pkt_a), 32'd3);
        flush_a        = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 18'h20077;
        #1;
        check("flush_mem_write", 32'(bus_a.mem_write), 32'd0);
        tick();
        flush_a        = 1'b0;
        bus_a.in_valid = 1'b0;
        check("flush7_count", 32'(count_a), 32'd0);
        check("flush7_pkt",   32'(pkt_a), 32'd0);
        check("flush7_empty", 32'(empty_a), 32'd1);

        // Empty, push with out_ready held high
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 18'h20055;
        bus_a.out_ready = 1'b1;
        #1;
        check("bypass_out_valid", 32'(bus_a.out_valid), 32'd0);
        tick();
        bus_a.in_valid = 1'b0;
        check("lat_out_valid", 32'(bus_a.out_valid), 32'd1);
        check("lat_out_data",  32'(bus_a.out_data), 32'h20055);
        check("lat_pkt",       32'(pkt_a), 32'd1);
        tick();
        bus_a.out_ready = 1'b0;
        check("drain_count",     32'(count_a), 32'd0);
        check("drain_pkt",       32'(pkt_a), 32'd0);
        check("drain_out_valid", 32'(bus_a.out_valid), 32'd0);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) push_a(first3[i]);
        check("pre_rst_count", 32'(count_a), 32'd3);
        #3;
        rst_a = 1'b0;
        #1;
        check("arst_count",     32'(count_a), 32'd0);
        check("arst_pkt",       32'(pkt_a), 32'd0);
        check("arst_empty",     32'(empty_a), 32'd1);
        check("arst_in_ready",  32'(bus_a.in_ready), 32'd1);
        check("arst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("arst_mem_read",  32'(bus_a.mem_read), 32'd0);
        #2;
        rst_a = 1'b1;
        tick();

        // LENGTH 5 streaming: 12 flits, continuous push/pop
        begin
            int unsigned sent = 0;
            int unsigned rcv  = 0;
            for (int cyc = 0; cyc < 40 && rcv < 12; cyc++) begin
                bus_b.in_valid  = (sent < 12);
                bus_b.in_data   = stream_flit(sent);
                bus_b.out_ready = 1'b1;
                #1;
                check("str_in_ready", 32'(bus_b.in_ready), 32'd1);
                if (bus_b.out_valid) begin
                    check("str_out_data", 32'(bus_b.out_data), 32'(stream_flit(rcv)));
                    check("str_rd_addr",  32'(bus_b.mem_read_addr), rcv % 5);
                    rcv++;
                end
                if (bus_b.in_valid) begin
                    check("str_wr_addr", 32'(bus_b.mem_write_addr), sent % 5);
                    sent++;
                end
                tick();
            end
            bus_b.in_valid  = 1'b0;
            bus_b.out_ready = 1'b0;
            check("str_received", rcv, 32'd12);
            check("str_count",    32'(count_b), 32'd0);
            check("str_pkt",      32'(pkt_b), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
